// File: rtl/vid_mem_arbiter_if.sv
// External memory port shared by CPU and video refresh.
// The arbiter drives the command side (master); the memory answers (slave).
interface vid_mem_arbiter_if #(
  parameter int ADR_W = 18
);
  logic             req;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [31:0]      wdata;
  logic [3:0]       be;
  logic             ack;
  logic [31:0]      rdata;

  modport master (output req, we, adr, wdata, be, input ack, rdata);
  modport slave  (input req, we, adr, wdata, be, output ack, rdata);
endinterface

// File: rtl/vid_mem_arbiter.sv
// Arbitrates the single memory port between video word fetches (priority)
// and CPU accesses, with a guaranteed CPU slot between back-to-back fetches.
//
// state | meaning
// IDLE  | no memory cycle; grant evaluated here every cycle
// VRD   | video word read in progress
// CRD   | CPU read in progress
// CWR   | CPU write in progress
module vid_mem_arbiter #(
  parameter int                ADR_W    = 18,
  parameter logic [ADR_W-16:0] VID_PAGE = 3'b111,
  parameter int                TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [14:0]       vid_adr,
  output logic [31:0]       vid_data,
  output logic              vid_valid,
  output logic              vid_overrun,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADR_W-1:0]  cpu_adr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  vid_mem_arbiter_if.master mem,
  output logic              mem_timeout
);

  typedef enum logic [1:0] {IDLE, VRD, CRD, CWR} state_t;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic             req_q, we_q;
  logic [ADR_W-1:0] adr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic             vid_pend_q, last_vid_q;
  logic [14:0]      vadr_q;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic [31:0]      vid_data_q;
  logic             vid_valid_q, overrun_q, timeout_q;

  logic             cpu_wait, vid_win, abort, ack_ok, done, cpu_cyc;
  logic [14:0]      vid_sel;

  always_comb begin
    cpu_wait = cpu_rd | cpu_wr;
    // last_vid forces one CPU slot between consecutive video fetches
    vid_win  = (vid_pend_q | vid_req) & ~(last_vid_q & cpu_wait);
    vid_sel  = vid_req ? vid_adr : vadr_q;
    abort    = req_q & (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
    ack_ok   = req_q & mem.ack & ~abort;
    done     = ack_ok | abort;
    cpu_cyc  = (state_q == CRD) | (state_q == CWR);
    state_d  = state_q;
    case (state_q)
      IDLE: begin
        if (vid_win)     state_d = VRD;
        else if (cpu_rd) state_d = CRD;
        else if (cpu_wr) state_d = CWR;
      end
      default: if (done) state_d = IDLE;
    endcase
    cpu_ack   = cpu_cyc & done;
    cpu_rdata = (state_q == CRD && ack_ok) ? mem.rdata : 32'h0;
    cpu_stall = cpu_wait & ~cpu_ack;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      vid_pend_q  <= 1'b0;
      last_vid_q  <= 1'b0;
      vadr_q      <= '0;
      tmo_cnt_q   <= '0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      req_q <= (state_q != IDLE) & ~done;
      if (!req_q)
        tmo_cnt_q <= '0;
      else if (tmo_cnt_q != CNT_W'(TIMEOUT))
        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      if (state_q == IDLE) begin
        if (vid_win) begin
          we_q    <= 1'b0;
          adr_q   <= {VID_PAGE, vid_sel};
          wdata_q <= '0;
          be_q    <= 4'hF;
        end else if (cpu_wait) begin
          we_q    <= cpu_wr;
          adr_q   <= cpu_adr;
          wdata_q <= cpu_wdata;
          be_q    <= cpu_be;
        end
      end
      if (vid_req) vadr_q <= vid_adr;
      if (state_q == IDLE && vid_win) vid_pend_q <= 1'b0;
      else if (vid_req)               vid_pend_q <= 1'b1;
      if (vid_req && (vid_pend_q || state_q == VRD)) overrun_q <= 1'b1;
      if (done) last_vid_q <= (state_q == VRD);
      vid_valid_q <= (state_q == VRD) & ack_ok;
      if (state_q == VRD && ack_ok) vid_data_q <= mem.rdata;
      if (abort) timeout_q <= 1'b1;
    end
  end

  assign mem.req     = req_q;
  assign mem.we      = we_q;
  assign mem.adr     = adr_q;
  assign mem.wdata   = wdata_q;
  assign mem.be      = be_q;
  assign vid_data    = vid_data_q;
  assign vid_valid   = vid_valid_q;
  assign vid_overrun = overrun_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_vid_mem_arbiter.sv
// Directed bench for vid_mem_arbiter: transaction-level model of the memory
// port checked every cycle, plus literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_vid_mem_arbiter;
  localparam int ADR_W   = 18;
  localparam int TIMEOUT = 64;
  localparam int K_VID = 0, K_CRD = 1, K_CWR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             vid_req = 1'b0;
  logic [14:0]      vid_adr = '0;
  logic [31:0]      vid_data;
  logic             vid_valid, vid_overrun;
  logic             cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [ADR_W-1:0] cpu_adr = '0;
  logic [31:0]      cpu_wdata = '0;
  logic [3:0]       cpu_be = '0;
  logic [31:0]      cpu_rdata;
  logic             cpu_ack, cpu_stall, mem_timeout;

  vid_mem_arbiter_if #(.ADR_W(ADR_W)) mem_bus ();

  vid_mem_arbiter #(.ADR_W(ADR_W), .VID_PAGE(3'b111), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_adr(vid_adr), .vid_data(vid_data),
    .vid_valid(vid_valid), .vid_overrun(vid_overrun),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .mem(mem_bus), .mem_timeout(mem_timeout)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] resp(input logic [ADR_W-1:0] a);
    return 32'hA500_0000 | {14'h0, a};
  endfunction

  // memory responder: ack after dly extra cycles of mem_req; dly<0 never acks
  int   dly = 3;
  int   k = 0;
  logic auto_ack = 1'b0, man_ack = 1'b0;
  assign mem_bus.ack   = auto_ack | man_ack;
  assign mem_bus.rdata = resp(mem_bus.adr);
  always @(posedge clk) begin
    #1;
    if (mem_bus.req) k = k + 1;
    else             k = 0;
    auto_ack = (dly >= 0) && mem_bus.req && (k == dly + 1);
  end

  typedef struct {
    int               kind;
    logic [ADR_W-1:0] adr;
    logic [31:0]      wdata;
    logic [3:0]       be;
  } cmd_t;
  cmd_t exp_q[$];
  cmd_t m_cur;

  task automatic push(input int kind, input logic [ADR_W-1:0] adr,
                      input logic [31:0] wdata, input logic [3:0] be);
    cmd_t c;
    c.kind = kind; c.adr = adr; c.wdata = wdata; c.be = be;
    exp_q.push_back(c);
  endtask

  task automatic chk_cmd();
    chk("mem_we", mem_bus.we, m_cur.kind == K_CWR);
    chk("mem_adr", mem_bus.adr, m_cur.adr);
    chk("mem_be", mem_bus.be, m_cur.be);
    if (m_cur.kind == K_CWR) chk("mem_wdata", mem_bus.wdata, m_cur.wdata);
  endtask

  // model state: one memory cycle at a time, in the order the tests queue them
  logic        rst_seen = 1'b1;
  bit          m_active = 0, m_gap = 0, m_vv = 0, m_tmo = 0;
  int          m_len = 0;
  logic [31:0] m_word = '0, m_pend = '0;
  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) begin : compare
    bit exp_ack, abort_now, ok_now;
    exp_ack = 0; abort_now = 0; ok_now = 0;
    if (rst_seen) begin
      chk("rst_mem_req", mem_bus.req, 0);
      chk("rst_vid_valid", vid_valid, 0);
      chk("rst_vid_data", vid_data, 0);
      chk("rst_overrun", vid_overrun, 0);
      chk("rst_timeout", mem_timeout, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      m_active = 0; m_gap = 0; m_vv = 0; m_tmo = 0; m_word = '0;
      exp_q.delete();
    end else begin
      if (m_vv) m_word = m_pend;
      chk("vid_valid", vid_valid, m_vv);
      chk("vid_data", vid_data, m_word);
      m_vv = 0;
      chk("mem_timeout", mem_timeout, m_tmo);
      if (m_gap) begin
        chk("req_gap", mem_bus.req, 0);
        m_gap = 0;
      end else if (m_active) begin
        chk("req_held", mem_bus.req, 1);
        chk_cmd();
      end else if (mem_bus.req) begin
        chk("req_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          m_cur = exp_q.pop_front();
          m_active = 1;
          m_len = 0;
          chk_cmd();
        end
      end
      if (m_active) begin
        m_len++;
        abort_now = (m_len == TIMEOUT);
        ok_now    = mem_bus.ack && !abort_now;
        if (m_cur.kind != K_VID && (ok_now || abort_now)) exp_ack = 1;
        if (m_cur.kind == K_VID && ok_now) begin
          m_vv = 1;
          m_pend = resp(m_cur.adr);
        end
        if (abort_now) m_tmo = 1;
        if (ok_now || abort_now) begin
          m_active = 0;
          m_gap = 1;
        end
      end
      chk("cpu_ack", cpu_ack, exp_ack);
      if (exp_ack)
        chk("cpu_rdata", cpu_rdata, (m_cur.kind == K_CRD && ok_now) ? resp(m_cur.adr) : 32'h0);
      chk("cpu_stall", cpu_stall, (cpu_rd | cpu_wr) & ~exp_ack);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cpu_ack(input string name, input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      step(); #2; n++;
      if (cpu_ack) break;
    end
    chk(name, cpu_ack, 1);
  endtask

  task automatic wait_vid_valid(input string name, input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      step(); #2; n++;
      if (vid_valid) break;
    end
    chk(name, vid_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) step();
    rst = 1'b0;
    step();

    // 1: lone video fetch, ack 3 cycles after mem_req rises
    dly = 3;
    push(K_VID, 18'h39234, 32'h0, 4'hF);
    vid_adr = 15'h1234; vid_req = 1'b1;
    step(); vid_req = 1'b0; #2;
    chk("t1_req_c1", mem_bus.req, 0);
    step(); #2;
    chk("t1_req_c2", mem_bus.req, 1);
    chk("t1_adr", mem_bus.adr, 18'h39234);
    chk("t1_be", mem_bus.be, 4'hF);
    chk("t1_we", mem_bus.we, 0);
    repeat (4) step();
    #2;
    chk("t1_valid_c6", vid_valid, 1);
    chk("t1_data", vid_data, 32'hA503_9234);
    step(); #2;
    chk("t1_valid_pulse", vid_valid, 0);
    chk("t1_data_held", vid_data, 32'hA503_9234);
    step();

    // 2: CPU write while idle
    push(K_CWR, 18'h00100, 32'hDEADBEEF, 4'h3);
    cpu_adr = 18'h00100; cpu_wdata = 32'hDEADBEEF; cpu_be = 4'h3; cpu_wr = 1'b1;
    #2; chk("t2_stall", cpu_stall, 1);
    step(); step(); #2;
    chk("t2_we", mem_bus.we, 1);
    chk("t2_adr", mem_bus.adr, 18'h00100);
    chk("t2_wdata", mem_bus.wdata, 32'hDEADBEEF);
    chk("t2_be", mem_bus.be, 4'h3);
    chk("t2_stall_wait", cpu_stall, 1);
    wait_cpu_ack("t2_ack", 20, n);
    chk("t2_ack_cycle", n, 3);
    chk("t2_rdata", cpu_rdata, 0);
    chk("t2_stall_ack", cpu_stall, 0);
    step(); cpu_wr = 1'b0; #2;
    chk("t2_ack_pulse", cpu_ack, 0);
    step();

    // 3: video and CPU together, second video request during VRD
    dly = 2;
    push(K_VID, 18'h38042, 32'h0, 4'hF);
    push(K_CRD, 18'h02345, 32'h0, 4'hF);
    push(K_VID, 18'h38777, 32'h0, 4'hF);
    vid_adr = 15'h0042; vid_req = 1'b1;
    cpu_adr = 18'h02345; cpu_be = 4'hF; cpu_rd = 1'b1;
    step(); vid_req = 1'b0;
    step();
    chk("t3_no_overrun", vid_overrun, 0);
    vid_adr = 15'h0777; vid_req = 1'b1;
    step(); vid_req = 1'b0; #2;
    chk("t3_overrun", vid_overrun, 1);
    wait_cpu_ack("t3_ack", 30, n);
    chk("t3_ack_cycle", n, 6);
    chk("t3_rdata", cpu_rdata, 32'hA500_2345);
    step(); cpu_rd = 1'b0;
    wait_vid_valid("t3_vid2", 30, n);
    chk("t3_vid2_cycle", n, 5);
    chk("t3_vid2_data", vid_data, 32'hA503_8777);
    chk("t3_all_cycles", exp_q.size(), 0);
    step(); step();

    // 4: CPU read with ack withheld -> timeout
    dly = -1;
    push(K_CRD, 18'h00ABC, 32'h0, 4'hF);
    cpu_adr = 18'h00ABC; cpu_be = 4'hF; cpu_rd = 1'b1;
    wait_cpu_ack("t4_ack", 100, n);
    chk("t4_ack_cycle", n, 65);
    chk("t4_rdata", cpu_rdata, 0);
    chk("t4_tmo_before", mem_timeout, 0);
    step(); cpu_rd = 1'b0; #2;
    chk("t4_req_drop", mem_bus.req, 0);
    chk("t4_tmo", mem_timeout, 1);
    step(); step();

    // 5: reset two cycles into a video read, then a late mem_ack
    push(K_VID, 18'h38555, 32'h0, 4'hF);
    vid_adr = 15'h0555; vid_req = 1'b1;
    step(); vid_req = 1'b0;
    step(); #2;
    chk("t5_req_on", mem_bus.req, 1);
    step(); rst = 1'b1;
    step(); rst = 1'b0; #2;
    chk("t5_req_off", mem_bus.req, 0);
    chk("t5_vid_data", vid_data, 0);
    chk("t5_tmo_clr", mem_timeout, 0);
    chk("t5_ovr_clr", vid_overrun, 0);
    step(); man_ack = 1'b1;
    step(); man_ack = 1'b0; #2;
    chk("t5_no_valid", vid_valid, 0);
    step(); #2;
    chk("t5_no_valid2", vid_valid, 0);
    step();
    dly = 1;
    push(K_CRD, 18'h01111, 32'h0, 4'h5);
    cpu_adr = 18'h01111; cpu_be = 4'h5; cpu_rd = 1'b1;
    wait_cpu_ack("t5_ack", 20, n);
    chk("t5_ack_cycle", n, 3);
    chk("t5_rdata", cpu_rdata, 32'hA500_1111);
    step(); cpu_rd = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
